alu_stage: RTL and testbench
============================

# alu_stage

Execute stage of the MIRI monocycle processor. It sits between decode/fetch and memory/writeback and performs four jobs:
- selects the ALU operation from the 2-bit main-control ALU_OP and the instruction function field, and computes the result;
- computes the branch target;
- forwards store data and the destination register index.

All outputs are registered once on the rising clock edge.

## Interface
Parameters: none (data width fixed at 32).

Clock and reset: one clock; reset is asynchronous and active-high.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all output registers.
- regA_data  in  32  operand A, read from the register file.
- regB_data  in  32  operand B / store data, read from the register file.
- lower_half_instruction  in  32  sign-extended instruction immediate.
  - [5:0] is funct; [10:6] is shamt; [15:11] is rd.
- PC_NEXT_in  in  32  PC+4 from fetch.
- ALU_OP  in  2  main-control ALU class.
- regD_data  out  32  ALU result.
- regB_data_out  out  32  registered copy of regB_data (store data).
- zero  out  1  high when the ALU result equals 0.
- PC_NEXT  out  32  branch target.
- regD  out  5  destination register, lower_half_instruction[15:11].

## Operation
Operand B selection:
- ALU_OP 00 or 11: lower_half_instruction (immediate).
- ALU_OP 01 or 10: regB_data.

ALU_OP decode:
- 00: ADD (load/store address).
- 01: SUB (beq compare).
- 11: OR (ori).
- 10: decode funct to a 4-bit alu_control.

Funct decode (ALU_OP = 10), with alu_control code:
- 100000 or 100001: ADD, 0010.
- 100010 or 100011: SUB, 0110.
- 100100: AND, 0000.
- 100101: OR, 0001.
- 100110: XOR, 0011.
- 100111: NOR, 1100.
- 101010: SLT (signed), 0111.
- 101011: SLTU, 1000.
- 000000: SLL B by shamt, 1001.
- 000010: SRL, 1010.
- 000011: SRA, 1011.
- Any other funct: 1111, result 0.

Arithmetic rules:
- All arithmetic is modulo 2^32.
- No overflow detection or trap.
- SLT/SLTU produce 32'd1 or 32'd0.

Other outputs:
- zero = (result == 0), computed on the same result that is registered.
- PC_NEXT = PC_NEXT_in + (lower_half_instruction << 2), modulo 2^32. It is computed on every cycle regardless of ALU_OP; branch decision is external.
- regD = lower_half_instruction[15:11]; regB_data_out = regB_data.

## Timing
- Combinational datapath; all five outputs are captured on the rising edge of clk.
- Latency: 1 cycle. No handshake; a new operation is accepted every cycle.
- Reset asserted, at any time including mid-operation: all outputs go to 0 immediately, asynchronously, including zero = 0. They stay 0 while reset is held.
- First capture occurs on the first rising edge after reset deasserts.
- Input changes between edges do not affect the outputs until the next edge.

## Structure
- Shared package holds:
  - ALU_OP codes (ALU_ADD=00, ALU_SUB=01, ALU_RTYPE=10, ALU_OR=11);
  - funct constants;
  - 4-bit alu_control encodings.
- One sub-module, alu_control: combinational, ALU_OP + funct -> alu_control[3:0].
- ALU, operand mux, branch adder and output registers live in alu_stage.

## Test plan
- Reset: hold reset with arbitrary inputs -> all outputs 0. Assert reset between edges -> outputs clear without waiting for a clock edge.
- R-type ADD: ALU_OP=10, instr=32'h0000_5820, A=5, B=7 -> after next edge regD_data=12, zero=0, regD=11, regB_data_out=7.
- beq compare and branch target: ALU_OP=01, A=B=32'h1234, PC_NEXT_in=32'h100, instr=32'h4 -> regD_data=0, zero=1, PC_NEXT=32'h110.
- Negative offset: instr=32'hFFFF_FFFF, PC_NEXT_in=32'h100 -> PC_NEXT=32'hFC.
- SLT vs SLTU: A=32'hFFFF_FFFF, B=1 -> funct 101010 gives 1; funct 101011 gives 0, zero=1.
- Load address: ALU_OP=00, A=32'h1000, instr=32'hFFFF_FFFC -> regD_data=32'hFFC.
- Undefined funct: ALU_OP=10 with funct 111111 -> regD_data=0, zero=1.

Source files
------------

// File: rtl/alu_stage_pkg.sv
// Shared definitions for the MIRI execute stage: ALU class codes,
// R-type funct values and the internal 4-bit ALU control encodings.
package alu_stage_pkg;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_RTYPE = 2'b10,
      ALU_OR    = 2'b11
   } alu_op_e;

   localparam logic [5:0] FUNCT_ADD  = 6'b100000;
   localparam logic [5:0] FUNCT_ADDU = 6'b100001;
   localparam logic [5:0] FUNCT_SUB  = 6'b100010;
   localparam logic [5:0] FUNCT_SUBU = 6'b100011;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_XOR  = 6'b100110;
   localparam logic [5:0] FUNCT_NOR  = 6'b100111;
   localparam logic [5:0] FUNCT_SLT  = 6'b101010;
   localparam logic [5:0] FUNCT_SLTU = 6'b101011;
   localparam logic [5:0] FUNCT_SLL  = 6'b000000;
   localparam logic [5:0] FUNCT_SRL  = 6'b000010;
   localparam logic [5:0] FUNCT_SRA  = 6'b000011;

   localparam logic [3:0] CTL_AND  = 4'b0000;
   localparam logic [3:0] CTL_OR   = 4'b0001;
   localparam logic [3:0] CTL_ADD  = 4'b0010;
   localparam logic [3:0] CTL_XOR  = 4'b0011;
   localparam logic [3:0] CTL_SUB  = 4'b0110;
   localparam logic [3:0] CTL_SLT  = 4'b0111;
   localparam logic [3:0] CTL_SLTU = 4'b1000;
   localparam logic [3:0] CTL_SLL  = 4'b1001;
   localparam logic [3:0] CTL_SRL  = 4'b1010;
   localparam logic [3:0] CTL_SRA  = 4'b1011;
   localparam logic [3:0] CTL_NOR  = 4'b1100;
   localparam logic [3:0] CTL_NONE = 4'b1111;

endpackage

// File: rtl/alu_stage_alu_control.sv
// Combinational ALU control: maps the main-control ALU class and the
// instruction funct field onto a 4-bit ALU operation code.
module alu_control
   import alu_stage_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [5:0] funct_i,
   output logic [3:0] alu_control_o
);

   logic [3:0] rtype_ctl_s;

   // Funct decode, only consulted for R-type instructions
   always_comb begin
      rtype_ctl_s = CTL_NONE;
      case (funct_i)
         FUNCT_ADD, FUNCT_ADDU: rtype_ctl_s = CTL_ADD;
         FUNCT_SUB, FUNCT_SUBU: rtype_ctl_s = CTL_SUB;
         FUNCT_AND:             rtype_ctl_s = CTL_AND;
         FUNCT_OR:              rtype_ctl_s = CTL_OR;
         FUNCT_XOR:             rtype_ctl_s = CTL_XOR;
         FUNCT_NOR:             rtype_ctl_s = CTL_NOR;
         FUNCT_SLT:             rtype_ctl_s = CTL_SLT;
         FUNCT_SLTU:            rtype_ctl_s = CTL_SLTU;
         FUNCT_SLL:             rtype_ctl_s = CTL_SLL;
         FUNCT_SRL:             rtype_ctl_s = CTL_SRL;
         FUNCT_SRA:             rtype_ctl_s = CTL_SRA;
         default:               rtype_ctl_s = CTL_NONE;
      endcase
   end

   // ALU class selects a fixed operation or defers to the funct decode
   always_comb begin
      alu_control_o = CTL_NONE;
      case (alu_op_i)
         ALU_ADD:   alu_control_o = CTL_ADD;
         ALU_SUB:   alu_control_o = CTL_SUB;
         ALU_OR:    alu_control_o = CTL_OR;
         ALU_RTYPE: alu_control_o = rtype_ctl_s;
         default:   alu_control_o = CTL_NONE;
      endcase
   end

endmodule

// File: rtl/alu_stage.sv
// MIRI execute stage: ALU, operand-B mux, branch-target adder and a single
// output register rank (one-cycle latency, async active-high reset).
module alu_stage
   import alu_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] regA_data,
   input  logic [31:0] regB_data,
   input  logic [31:0] lower_half_instruction,
   input  logic [31:0] PC_NEXT_in,
   input  logic [1:0]  ALU_OP,
   output logic [31:0] regD_data,
   output logic [31:0] regB_data_out,
   output logic        zero,
   output logic [31:0] PC_NEXT,
   output logic [4:0]  regD
);

   logic [3:0]  alu_ctl_s;
   logic [31:0] op_b_s;
   logic [4:0]  shamt_s;

   logic [31:0] result_d,  result_q;
   logic [31:0] store_d,   store_q;
   logic        zero_d,    zero_q;
   logic [31:0] target_d,  target_q;
   logic [4:0]  rd_d,      rd_q;

   alu_control u_alu_control (
      .alu_op_i      (ALU_OP),
      .funct_i       (lower_half_instruction[5:0]),
      .alu_control_o (alu_ctl_s)
   );

   assign shamt_s = lower_half_instruction[10:6];

   // Immediate classes (load/store, ori) take the immediate as operand B
   always_comb begin
      op_b_s = regB_data;
      case (ALU_OP)
         ALU_ADD, ALU_OR:     op_b_s = lower_half_instruction;
         ALU_SUB, ALU_RTYPE:  op_b_s = regB_data;
         default:             op_b_s = regB_data;
      endcase
   end

   // ALU core; shifts act on operand B, undefined codes yield zero
   always_comb begin
      result_d = 32'd0;
      case (alu_ctl_s)
         CTL_ADD:  result_d = regA_data + op_b_s;
         CTL_SUB:  result_d = regA_data - op_b_s;
         CTL_AND:  result_d = regA_data & op_b_s;
         CTL_OR:   result_d = regA_data | op_b_s;
         CTL_XOR:  result_d = regA_data ^ op_b_s;
         CTL_NOR:  result_d = ~(regA_data | op_b_s);
         CTL_SLT:  result_d = ($signed(regA_data) < $signed(op_b_s)) ? 32'd1 : 32'd0;
         CTL_SLTU: result_d = (regA_data < op_b_s) ? 32'd1 : 32'd0;
         CTL_SLL:  result_d = op_b_s << shamt_s;
         CTL_SRL:  result_d = op_b_s >> shamt_s;
         CTL_SRA:  result_d = 32'($signed(op_b_s) >>> shamt_s);
         default:  result_d = 32'd0;
      endcase
   end

   assign zero_d   = (result_d == 32'd0);
   assign target_d = PC_NEXT_in + {lower_half_instruction[29:0], 2'b00};
   assign store_d  = regB_data;
   assign rd_d     = lower_half_instruction[15:11];

   // Output register rank
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q <= 32'd0;
         store_q  <= 32'd0;
         zero_q   <= 1'b0;
         target_q <= 32'd0;
         rd_q     <= 5'd0;
      end else begin
         result_q <= result_d;
         store_q  <= store_d;
         zero_q   <= zero_d;
         target_q <= target_d;
         rd_q     <= rd_d;
      end
   end

   assign regD_data     = result_q;
   assign regB_data_out = store_q;
   assign zero          = zero_q;
   assign PC_NEXT       = target_q;
   assign regD          = rd_q;

endmodule

// File: tb/tb_alu_stage.sv
// Directed self-checking bench for alu_stage with hand-computed vectors.
module tb_alu_stage;

   logic        clk;
   logic        reset;
   logic [31:0] regA_data;
   logic [31:0] regB_data;
   logic [31:0] lower_half_instruction;
   logic [31:0] PC_NEXT_in;
   logic [1:0]  ALU_OP;
   logic [31:0] regD_data;
   logic [31:0] regB_data_out;
   logic        zero;
   logic [31:0] PC_NEXT;
   logic [4:0]  regD;

   int n_cmp;
   int n_bad;

   alu_stage dut (
      .clk                    (clk),
      .reset                  (reset),
      .regA_data              (regA_data),
      .regB_data              (regB_data),
      .lower_half_instruction (lower_half_instruction),
      .PC_NEXT_in             (PC_NEXT_in),
      .ALU_OP                 (ALU_OP),
      .regD_data              (regD_data),
      .regB_data_out          (regB_data_out),
      .zero                   (zero),
      .PC_NEXT                (PC_NEXT),
      .regD                   (regD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] instr, input logic [31:0] pc);
      ALU_OP                 = op;
      regA_data              = a;
      regB_data              = b;
      lower_half_instruction = instr;
      PC_NEXT_in             = pc;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(2'b10, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_5820, 32'h0000_0400);
      step();
      step();
      n_cmp++; if (regD_data !== 32'd0) begin n_bad++; $display("FAIL reset_regD_data got %h exp %h", regD_data, 32'd0); end
      n_cmp++; if (regB_data_out !== 32'd0) begin n_bad++; $display("FAIL reset_regB_out got %h exp %h", regB_data_out, 32'd0); end
      n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL reset_zero got %b exp %b", zero, 1'b0); end
      n_cmp++; if (PC_NEXT !== 32'd0) begin n_bad++; $display("FAIL reset_PC_NEXT got %h exp %h", PC_NEXT, 32'd0); end
      n_cmp++; if (regD !== 5'd0) begin n_bad++; $display("FAIL reset_regD got %h exp %h", regD, 5'd0); end
      reset = 1'b0;
   endtask

   task automatic test_rtype_add();
      drive(2'b10, 32'd5, 32'd7, 32'h0000_5820, 32'h0000_0200);
      step();
      n_cmp++; if (regD_data !== 32'd12) begin n_bad++; $display("FAIL add_result got %h exp %h", regD_data, 32'd12); end
      n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL add_zero got %b exp %b", zero, 1'b0); end
      n_cmp++; if (regD !== 5'd11) begin n_bad++; $display("FAIL add_regD got %0d exp %0d", regD, 5'd11); end
      n_cmp++; if (regB_data_out !== 32'd7) begin n_bad++; $display("FAIL add_regB_out got %h exp %h", regB_data_out, 32'd7); end
      n_cmp++; if (PC_NEXT !== 32'h0001_6280) begin n_bad++; $display("FAIL add_PC_NEXT got %h exp %h", PC_NEXT, 32'h0001_6280); end
   endtask

   task automatic test_beq_branch();
      drive(2'b01, 32'h1234, 32'h1234, 32'h0000_0004, 32'h0000_0100);
      step();
      n_cmp++; if (regD_data !== 32'd0) begin n_bad++; $display("FAIL beq_result got %h exp %h", regD_data, 32'd0); end
      n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL beq_zero got %b exp %b", zero, 1'b1); end
      n_cmp++; if (PC_NEXT !== 32'h0000_0110) begin n_bad++; $display("FAIL beq_PC_NEXT got %h exp %h", PC_NEXT, 32'h0000_0110); end
      n_cmp++; if (regB_data_out !== 32'h1234) begin n_bad++; $display("FAIL beq_regB_out got %h exp %h", regB_data_out, 32'h1234); end
      drive(2'b01, 32'd3, 32'd5, 32'h0000_0004, 32'h0000_0100);
      step();
      n_cmp++; if (regD_data !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL bne_result got %h exp %h", regD_data, 32'hFFFF_FFFE); end
      n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL bne_zero got %b exp %b", zero, 1'b0); end
   endtask

   task automatic test_negative_offset();
      drive(2'b00, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'h0000_0100);
      step();
      n_cmp++; if (PC_NEXT !== 32'h0000_00FC) begin n_bad++; $display("FAIL negoff_PC_NEXT got %h exp %h", PC_NEXT, 32'h0000_00FC); end
      n_cmp++; if (regD !== 5'd31) begin n_bad++; $display("FAIL negoff_regD got %0d exp %0d", regD, 5'd31); end
   endtask

   task automatic test_slt_sltu();
      drive(2'b10, 32'hFFFF_FFFF, 32'd1, 32'h0000_002A, 32'd0);
      step();
      n_cmp++; if (regD_data !== 32'd1) begin n_bad++; $display("FAIL slt_result got %h exp %h", regD_data, 32'd1); end
      n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL slt_zero got %b exp %b", zero, 1'b0); end
      drive(2'b10, 32'hFFFF_FFFF, 32'd1, 32'h0000_002B, 32'd0);
      step();
      n_cmp++; if (regD_data !== 32'd0) begin n_bad++; $display("FAIL sltu_result got %h exp %h", regD_data, 32'd0); end
      n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL sltu_zero got %b exp %b", zero, 1'b1); end
   endtask

   task automatic test_load_addr();
      drive(2'b00, 32'h0000_1000, 32'h5555_5555, 32'hFFFF_FFFC, 32'd0);
      step();
      n_cmp++; if (regD_data !== 32'h0000_0FFC) begin n_bad++; $display("FAIL load_addr got %h exp %h", regD_data, 32'h0000_0FFC); end
      n_cmp++; if (regB_data_out !== 32'h5555_5555) begin n_bad++; $display("FAIL load_regB_out got %h exp %h", regB_data_out, 32'h5555_5555); end
   endtask

   task automatic test_undefined_funct();
      drive(2'b10, 32'd5, 32'd9, 32'h0000_003F, 32'd0);
      step();
      n_cmp++; if (regD_data !== 32'd0) begin n_bad++; $display("FAIL undef_result got %h exp %h", regD_data, 32'd0); end
      n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL undef_zero got %b exp %b", zero, 1'b1); end
   endtask

   // Remaining operations: {ALU_OP, A, B, instr, expected result}
   task automatic test_alu_ops();
      logic [1:0]  ops [9]  = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
      logic [31:0] va  [9]  = '{32'h0F0, 32'd0, 32'd0, 32'h0000_F0F0, 32'h0000_FF0F, 32'h0000_FF0F, 32'd0, 32'd0, 32'd0};
      logic [31:0] vb  [9]  = '{32'hFFFF_0000, 32'd1, 32'd0, 32'h0000_FF00, 32'h0000_0FF0, 32'h0000_0FF0,
                                32'd1, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] vi  [9]  = '{32'h0000_000F, 32'h0000_0022, 32'h0000_0027, 32'h0000_0026, 32'h0000_0024,
                                32'h0000_0025, 32'h0000_07C0, 32'h0000_0102, 32'h0000_0103};
      logic [31:0] ve  [9]  = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0FF0, 32'h0000_0F00,
                                32'h0000_FFFF, 32'h8000_0000, 32'h0800_0000, 32'hF800_0000};
      for (int i = 0; i < 9; i++) begin
         drive(ops[i], va[i], vb[i], vi[i], 32'd0);
         step();
         n_cmp++; if (regD_data !== ve[i]) begin n_bad++; $display("FAIL alu_op_%0d got %h exp %h", i, regD_data, ve[i]); end
      end
   endtask

   task automatic test_back_to_back();
      drive(2'b10, 32'd100, 32'd1, 32'h0000_0822, 32'h0000_0010);
      step();
      drive(2'b10, 32'd2, 32'd3, 32'h0000_1020, 32'h0000_0020);
      n_cmp++; if (regD_data !== 32'd99) begin n_bad++; $display("FAIL b2b_first got %h exp %h", regD_data, 32'd99); end
      #2;
      n_cmp++; if (regD !== 5'd1) begin n_bad++; $display("FAIL b2b_hold_regD got %0d exp %0d", regD, 5'd1); end
      step();
      n_cmp++; if (regD_data !== 32'd5) begin n_bad++; $display("FAIL b2b_second got %h exp %h", regD_data, 32'd5); end
      n_cmp++; if (regD !== 5'd2) begin n_bad++; $display("FAIL b2b_regD got %0d exp %0d", regD, 5'd2); end
   endtask

   task automatic test_async_reset();
      drive(2'b10, 32'd5, 32'd7, 32'h0000_5820, 32'h0000_0200);
      step();
      #2;
      reset = 1'b1;
      #1;
      n_cmp++; if (regD_data !== 32'd0) begin n_bad++; $display("FAIL areset_result got %h exp %h", regD_data, 32'd0); end
      n_cmp++; if (PC_NEXT !== 32'd0) begin n_bad++; $display("FAIL areset_PC_NEXT got %h exp %h", PC_NEXT, 32'd0); end
      n_cmp++; if (regB_data_out !== 32'd0) begin n_bad++; $display("FAIL areset_regB_out got %h exp %h", regB_data_out, 32'd0); end
      n_cmp++; if (regD !== 5'd0) begin n_bad++; $display("FAIL areset_regD got %0d exp %0d", regD, 5'd0); end
      drive(2'b01, 32'd4, 32'd4, 32'd0, 32'd0);
      step();
      n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL areset_zero_held got %b exp %b", zero, 1'b0); end
      reset = 1'b0;
      step();
      n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL post_reset_zero got %b exp %b", zero, 1'b1); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_rtype_add();
      test_beq_branch();
      test_negative_offset();
      test_slt_sltu();
      test_load_addr();
      test_undefined_funct();
      test_alu_ops();
      test_back_to_back();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
